pipe_scroller: RTL and testbench
================================

PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 SHALL: N_OBJ, default 5, number of scrolling obstacles (2..8).
REQ-002 SHALL: XW, default 10, coordinate width in bits.
REQ-003 SHALL: PIPE_W, default 61, obstacle width in pixels.
REQ-004 SHALL: INTERVAL, default 142, initial spacing between left edges.
REQ-005 SHALL: SCREEN_W, default 640, respawn left-edge position.
REQ-006 SHALL: BIRD_X, default 230, pass threshold.
REQ-007 SHALL: SCORE_W, default 8, score width.
REQ-008 SHALL: clk  in  1  single clock; all state changes on its rising edge.
REQ-009 SHALL: reset_n  in  1  asynchronous, active-low reset.
REQ-010 SHALL: start, stop, ack  in  1 each  game control levels.
REQ-011 SHALL: tick  in  1  scroll strobe; movement occurs only on cycles with tick=1.
REQ-012 SHALL: step  in  2  pixels per tick, 0 = freeze.
REQ-013 SHALL: x_left, x_right  out  N_OBJ*XW each  edges packed in scope order; slot 0 = current obstacle.
REQ-014 SHALL: cur_idx  out  3  physical index of current obstacle.
REQ-015 SHALL: score  out  SCORE_W  passed-obstacle count.
REQ-016 SHALL: pass_p  out  1  one-cycle pulse per obstacle passed.
REQ-017 SHALL: q_initial, q_count, q_stop  out  1 each  one-hot state.

Function
REQ-018 SHALL: states INIT, COUNT, STOP; INIT->COUNT on start, COUNT->STOP on stop, STOP->INIT on ack; other input combinations hold state.
REQ-019 SHALL: while in INIT, every cycle load left[i]=i*INTERVAL, right[i]=left[i]+PIPE_W, cur_idx=2 mod N_OBJ, score=0.
REQ-020 SHALL: in COUNT with tick=1 and stop=0, left[i] and right[i] decrease by step, all arithmetic XW bits unsigned.
REQ-021 SHALL: left[i] saturate at 0 when left[i] < step.
REQ-022 SHALL: when right[i] <= step on a move, respawn left[i]=SCREEN_W, right[i]=SCREEN_W+PIPE_W in that same cycle.
REQ-023 SHALL: when right[cur_idx] < BIRD_X in COUNT, cur_idx advance mod N_OBJ next cycle, pass_p=1 for one cycle, score+1 saturating at all-ones.
REQ-024 SHALL: stop has priority: on a cycle with stop=1 in COUNT no move, no pass, no score change; state goes STOP.
REQ-025 SHALL: in STOP all coordinates, cur_idx and score hold.
REQ-026 SHALL: output slot k present obstacle (cur_idx+k) mod N_OBJ, combinationally from registers (zero latency).
REQ-027 SHALL: at most one pass per cycle.

Reset
REQ-028 SHALL: reset_n=0 force INIT immediately and load REQ-019 values; pass_p=0.
REQ-029 SHALL: reset asserted mid-COUNT or mid-STOP discard all progress; first post-reset cycle with start=1 enter COUNT.

Configuration
REQ-030 SHALL: with PIPE_SCROLLER_COIN_EN defined, add ports coin_left/coin_right (N_OBJ*XW, out, same scope order) and coin_sync_p (1, out); coin i width COIN_W (parameter, default 20), initial left=i*INTERVAL, scroll identically, respawn left=SCREEN_W+PIPE_W-COIN_W, right=SCREEN_W+PIPE_W; coin_sync_p pulse when current coin right equals BIRD_X.
REQ-031 SHALL: without PIPE_SCROLLER_COIN_EN, those ports and registers are absent; all other behaviour identical.

Structure
REQ-032 SHALL: state encodings and default geometry constants live in shared package flappy_pkg.
REQ-033 SHALL: one sub-module scroll_track (one edge pair: load, move, saturate, respawn), instantiated N_OBJ times (and N_OBJ more under coin option).

Verification
REQ-034 SHALL: reset_n low, release, start=0 for 5 cycles -> q_initial=1, slot0 left=284, right=345, cur_idx=2, score=0.
REQ-035 SHALL: start, tick=1, step=1 for 116 cycles -> slot0 right=229, next cycle cur_idx=3, pass_p=1 once, score=1.
REQ-036 SHALL: obstacle 0 scroll with step=2 from left=0,right=61 -> left holds 0, right reaches 1 then respawns to 640/701 on next tick.
REQ-037 SHALL: stop asserted on cycle of pass condition -> no pass_p, score unchanged, q_stop=1; ack -> q_initial, values reloaded.
REQ-038 SHALL: score at 255 with another pass -> score stays 255, pass_p still pulses.
REQ-039 SHALL: N_OBJ=3 build, 4 passes -> cur_idx sequence 2,0,1,2,0.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared definitions for the scrolling-obstacle game blocks: controller state
// encoding, default geometry and a small modular index helper.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  localparam int DEF_N_OBJ    = 5;
  localparam int DEF_XW       = 10;
  localparam int DEF_PIPE_W   = 61;
  localparam int DEF_INTERVAL = 142;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_BIRD_X   = 230;
  localparam int DEF_SCORE_W  = 8;
  localparam int DEF_COIN_W   = 20;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/scroll_track.sv
// One scrolling edge pair. Loads its start position, moves left by step,
// clamps the left edge at zero and respawns at the right side of the screen
// once the right edge would reach zero.
module scroll_track
  import flappy_pkg::*;
#(
  parameter int            XW     = DEF_XW,
  parameter logic [XW-1:0] INIT_L = '0,
  parameter logic [XW-1:0] INIT_R = '0,
  parameter logic [XW-1:0] RESP_L = '0,
  parameter logic [XW-1:0] RESP_R = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          move,
  input  logic [1:0]    step,
  output logic [XW-1:0] left,
  output logic [XW-1:0] right
);

  logic [XW-1:0] step_x;

  assign step_x = {{(XW-2){1'b0}}, step};

  // edge pair register: load, then scroll with saturation and respawn
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left  <= INIT_L;
      right <= INIT_R;
    end else if (load) begin
      left  <= INIT_L;
      right <= INIT_R;
    end else if (move) begin
      if (right <= step_x) begin
        left  <= RESP_L;
        right <= RESP_R;
      end else begin
        left  <= (left < step_x) ? '0 : left - step_x;
        right <= right - step_x;
      end
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Obstacle scroller and pass counter for the side-scrolling game.
// Optional build macro PIPE_SCROLLER_COIN_EN adds a second set of tracks for
// coins plus a sync pulse when the current coin's right edge meets the bird.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | reload start geometry every cycle, wait for start
// ST_COUNT | scroll on tick, count passes, leave on stop
// ST_STOP  | freeze everything, wait for ack to return to ST_INIT
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int N_OBJ    = DEF_N_OBJ,
  parameter int XW       = DEF_XW,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int BIRD_X   = DEF_BIRD_X,
  parameter int SCORE_W  = DEF_SCORE_W
`ifdef PIPE_SCROLLER_COIN_EN
  ,
  parameter int COIN_W   = DEF_COIN_W
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  ack,
  input  logic                  tick,
  input  logic [1:0]            step,
  output logic [N_OBJ*XW-1:0]   x_left,
  output logic [N_OBJ*XW-1:0]   x_right,
  output logic [2:0]            cur_idx,
  output logic [SCORE_W-1:0]    score,
  output logic                  pass_p,
  output logic                  q_initial,
  output logic                  q_count,
  output logic                  q_stop
`ifdef PIPE_SCROLLER_COIN_EN
  ,
  output logic [N_OBJ*XW-1:0]   coin_left,
  output logic [N_OBJ*XW-1:0]   coin_right,
  output logic                  coin_sync_p
`endif
);

  localparam logic [2:0]    CUR_INIT = 3'(2 % N_OBJ);
  localparam logic [XW-1:0] BIRD_XV  = XW'(BIRD_X);

  state_t               state_q, state_d;
  logic                 load, move, pass_c;
  logic [2:0]           cur_idx_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 pass_q;
  logic [XW-1:0]        left_q  [N_OBJ];
  logic [XW-1:0]        right_q [N_OBJ];
  logic [XW-1:0]        cur_right;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // next state and per-cycle controls; stop blocks both movement and passes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    move    = 1'b0;
    pass_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        load = 1'b1;
        if (start) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (stop) begin
          state_d = ST_STOP;
        end else begin
          move   = tick;
          pass_c = (cur_right < BIRD_XV);
        end
      end
      ST_STOP: begin
        if (ack) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // right edge of the obstacle the bird is currently facing
  always_comb begin
    cur_right = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (cur_idx_q == 3'(i)) cur_right = right_q[i];
    end
  end

  // current index, saturating score and the registered pass pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_idx_q <= CUR_INIT;
      score_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      pass_q <= pass_c;
      if (load) begin
        cur_idx_q <= CUR_INIT;
        score_q   <= '0;
      end else if (pass_c) begin
        cur_idx_q <= (cur_idx_q == 3'(N_OBJ-1)) ? 3'd0 : cur_idx_q + 3'd1;
        if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + SCORE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pipe
    scroll_track #(
      .XW     (XW),
      .INIT_L (XW'(g*INTERVAL)),
      .INIT_R (XW'(g*INTERVAL + PIPE_W)),
      .RESP_L (XW'(SCREEN_W)),
      .RESP_R (XW'(SCREEN_W + PIPE_W))
    ) u_track (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .move    (move),
      .step    (step),
      .left    (left_q[g]),
      .right   (right_q[g])
    );
  end

  // rotate physical slots so output slot 0 is always the current obstacle
  always_comb begin
    x_left  = '0;
    x_right = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      x_left [k*XW +: XW] = left_q [wrap_idx(int'(cur_idx_q), k, N_OBJ)];
      x_right[k*XW +: XW] = right_q[wrap_idx(int'(cur_idx_q), k, N_OBJ)];
    end
  end

  assign cur_idx   = cur_idx_q;
  assign score     = score_q;
  assign pass_p    = pass_q;
  assign q_initial = (state_q == ST_INIT);
  assign q_count   = (state_q == ST_COUNT);
  assign q_stop    = (state_q == ST_STOP);

`ifdef PIPE_SCROLLER_COIN_EN
  logic [XW-1:0] cleft_q  [N_OBJ];
  logic [XW-1:0] cright_q [N_OBJ];
  logic [XW-1:0] cur_cright;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_coin
    scroll_track #(
      .XW     (XW),
      .INIT_L (XW'(g*INTERVAL)),
      .INIT_R (XW'(g*INTERVAL + COIN_W)),
      .RESP_L (XW'(SCREEN_W + PIPE_W - COIN_W)),
      .RESP_R (XW'(SCREEN_W + PIPE_W))
    ) u_track (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .move    (move),
      .step    (step),
      .left    (cleft_q[g]),
      .right   (cright_q[g])
    );
  end

  // coin outputs in the same rotated order, plus the current coin's right edge
  always_comb begin
    coin_left  = '0;
    coin_right = '0;
    cur_cright = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      coin_left [k*XW +: XW] = cleft_q [wrap_idx(int'(cur_idx_q), k, N_OBJ)];
      coin_right[k*XW +: XW] = cright_q[wrap_idx(int'(cur_idx_q), k, N_OBJ)];
      if (cur_idx_q == 3'(k)) cur_cright = cright_q[k];
    end
  end

  assign coin_sync_p = (state_q == ST_COUNT) && (cur_cright == BIRD_XV);
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: a behavioural model predicts positions and
// passes; pass events go through a scoreboard queue; a second N_OBJ=3 instance
// checks the current-index rotation.
module tb_pipe_scroller;

  logic        clk;
  logic        reset_n;
  logic        start, stop, ack, tick;
  logic [1:0]  step;
  logic [49:0] x_left, x_right;
  logic [2:0]  cur_idx;
  logic [7:0]  score;
  logic        pass_p, q_initial, q_count, q_stop;

  logic        start3, stop3, ack3;
  logic [29:0] x_left3, x_right3;
  logic [2:0]  cur_idx3;
  logic [7:0]  score3;
  logic        pass_p3, q_initial3, q_count3, q_stop3;

`ifdef PIPE_SCROLLER_COIN_EN
  logic [49:0] coin_left, coin_right;
  logic        coin_sync_p;
  logic [29:0] coin_left3, coin_right3;
  logic        coin_sync_p3;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // behavioural model of the default (N_OBJ=5) build
  int ml [5];
  int mr [5];
  int mcur, mscore, mst;
  bit mpass;
  logic [10:0] sb [$];
  logic [10:0] sb_e;
  int q3 [$] = '{2, 0, 1, 2, 0};

  pipe_scroller dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .ack(ack),
    .tick(tick), .step(step), .x_left(x_left), .x_right(x_right),
    .cur_idx(cur_idx), .score(score), .pass_p(pass_p),
    .q_initial(q_initial), .q_count(q_count), .q_stop(q_stop)
`ifdef PIPE_SCROLLER_COIN_EN
    , .coin_left(coin_left), .coin_right(coin_right), .coin_sync_p(coin_sync_p)
`endif
  );

  pipe_scroller #(.N_OBJ(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .stop(stop3), .ack(ack3),
    .tick(tick), .step(step), .x_left(x_left3), .x_right(x_right3),
    .cur_idx(cur_idx3), .score(score3), .pass_p(pass_p3),
    .q_initial(q_initial3), .q_count(q_count3), .q_stop(q_stop3)
`ifdef PIPE_SCROLLER_COIN_EN
    , .coin_left(coin_left3), .coin_right(coin_right3), .coin_sync_p(coin_sync_p3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] exp_vec(input bit use_right);
    logic [49:0] v;
    int idx;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      idx = (mcur + k) % 5;
      v[k*10 +: 10] = use_right ? 10'(mr[idx]) : 10'(ml[idx]);
    end
    return v;
  endfunction

  // model update, mirrors the game rules independently of the RTL structure
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || mst == 0) begin
      for (int i = 0; i < 5; i++) begin
        ml[i] <= i * 142;
        mr[i] <= i * 142 + 61;
      end
      mcur   <= 2;
      mscore <= 0;
      mpass  <= 0;
      if (!reset_n)   mst <= 0;
      else if (start) mst <= 1;
    end else if (mst == 1) begin
      if (stop) begin
        mpass <= 0;
        mst   <= 2;
      end else begin
        if (tick) begin
          for (int i = 0; i < 5; i++) begin
            if (mr[i] <= int'(step)) begin
              ml[i] <= 640;
              mr[i] <= 701;
            end else begin
              ml[i] <= (ml[i] < int'(step)) ? 0 : ml[i] - int'(step);
              mr[i] <= mr[i] - int'(step);
            end
          end
        end
        if (mr[mcur] < 230) begin
          mcur   <= (mcur + 1) % 5;
          mscore <= (mscore < 255) ? mscore + 1 : 255;
          mpass  <= 1;
          sb.push_back({3'((mcur + 1) % 5), 8'((mscore < 255) ? mscore + 1 : 255)});
        end else begin
          mpass <= 0;
        end
      end
    end else begin
      mpass <= 0;
      if (ack) mst <= 0;
    end
  end

  // per-cycle comparison against the model plus scoreboard pops
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_x_left", 64'(x_left), 64'(exp_vec(1'b0)));
      chk("cyc_x_right", 64'(x_right), 64'(exp_vec(1'b1)));
      chk("cyc_cur_idx", 64'(cur_idx), 64'(mcur));
      chk("cyc_score", 64'(score), 64'(mscore));
      chk("cyc_pass_p", 64'(pass_p), 64'(mpass));
      chk("cyc_onehot", 64'({q_initial, q_count, q_stop}),
          64'({mst == 0, mst == 1, mst == 2}));
      if (pass_p) begin
        chk("sb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          sb_e = sb.pop_front();
          chk("sb_pass", 64'({cur_idx, score}), 64'(sb_e));
        end
      end
      if (pass_p3 && q3.size() != 0) chk("n3_cur_seq", 64'(cur_idx3), 64'(q3.pop_front()));
    end
  end

  initial begin
    int n;
    reset_n = 1'b1;
    start = 0; stop = 0; ack = 0; tick = 0; step = 2'd0;
    start3 = 1; stop3 = 0; ack3 = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q_initial", 64'(q_initial), 64'd1);
    chk("rst_pass_p", 64'(pass_p), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1;

    // idle in INIT
    repeat (5) @(negedge clk);
    chk("init_q_initial", 64'(q_initial), 64'd1);
    chk("init_slot0_left", 64'(x_left[9:0]), 64'd284);
    chk("init_slot0_right", 64'(x_right[9:0]), 64'd345);
    chk("init_cur_idx", 64'(cur_idx), 64'd2);
    chk("init_score", 64'(score), 64'd0);
    chk("n3_init_cur", 64'(cur_idx3), 64'(q3.pop_front()));

    // first pass after 116 one-pixel moves
    start = 1; tick = 1; step = 2'd1;
    @(negedge clk);
    start = 0;
    repeat (116) @(negedge clk);
    chk("mv116_right", 64'(x_right[9:0]), 64'd229);
    chk("mv116_left", 64'(x_left[9:0]), 64'd168);
    chk("mv116_cur", 64'(cur_idx), 64'd2);
    @(negedge clk);
    chk("pass1_cur", 64'(cur_idx), 64'd3);
    chk("pass1_pulse", 64'(pass_p), 64'd1);
    chk("pass1_score", 64'(score), 64'd1);
    @(negedge clk);
    chk("pass1_pulse_end", 64'(pass_p), 64'd0);

    // stop on the exact cycle of a pass condition
    n = 0;
    while (!(mr[mcur] < 230) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("stop_wait_timeout", 64'(n < 2000), 64'd1);
    stop = 1;
    @(negedge clk);
    chk("stop_q_stop", 64'(q_stop), 64'd1);
    chk("stop_no_pass", 64'(pass_p), 64'd0);
    chk("stop_score", 64'(score), 64'd1);
    chk("stop_cur", 64'(cur_idx), 64'd3);
    stop = 0;
    @(negedge clk);
    chk("stop_hold", 64'(q_stop), 64'd1);
    ack = 1;
    @(negedge clk);
    chk("ack_q_initial", 64'(q_initial), 64'd1);
    ack = 0; tick = 0;
    @(negedge clk);
    chk("reload_left", 64'(x_left[9:0]), 64'd284);
    chk("reload_right", 64'(x_right[9:0]), 64'd345);
    chk("reload_cur", 64'(cur_idx), 64'd2);
    chk("reload_score", 64'(score), 64'd0);

    // obstacle 0 (slot 3) saturates at left 0 and respawns
    start = 1; tick = 1; step = 2'd2;
    @(negedge clk);
    start = 0;
    repeat (30) @(negedge clk);
    chk("sat_cur", 64'(cur_idx), 64'd2);
    chk("sat_left0", 64'(x_left[39:30]), 64'd0);
    chk("sat_right1", 64'(x_right[39:30]), 64'd1);
    @(negedge clk);
    chk("respawn_left", 64'(x_left[39:30]), 64'd640);
    chk("respawn_right", 64'(x_right[39:30]), 64'd701);
    chk("step2_slot0_right", 64'(x_right[9:0]), 64'd283);

    // freeze with step 0, then no tick
    step = 2'd0;
    repeat (3) @(negedge clk);
    chk("freeze_step0", 64'(x_right[9:0]), 64'd283);
    tick = 0; step = 2'd1;
    repeat (3) @(negedge clk);
    chk("freeze_notick", 64'(x_right[9:0]), 64'd283);

    // drive score to saturation and one pass beyond
    tick = 1; step = 2'd3;
    n = 0;
    while (mscore < 255 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("score_run_timeout", 64'(n < 40000), 64'd1);
    @(negedge clk);
    n = 0;
    while (!mpass && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_pass_timeout", 64'(n < 2000), 64'd1);
    chk("sat_score", 64'(score), 64'd255);
    chk("sat_pass_pulse", 64'(pass_p), 64'd1);

    // asynchronous reset in the middle of COUNT
    chk("pre_reset_count", 64'(q_count), 64'd1);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_q_initial", 64'(q_initial), 64'd1);
    chk("midrst_pass_p", 64'(pass_p), 64'd0);
    chk("midrst_score", 64'(score), 64'd0);
    chk("midrst_cur", 64'(cur_idx), 64'd2);
    chk("midrst_left", 64'(x_left[9:0]), 64'd284);
    @(negedge clk);
    reset_n = 1'b1;
    start = 1;
    @(negedge clk);
    chk("post_rst_count", 64'(q_count), 64'd1);
    start = 0;
    @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("n3_seq_done", 64'(q3.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
